// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the router controller; DROP_PKT exists only with ROUTER_CTRL_DROP_EN
package router_pkg;
  localparam int PORTS = 3;
  localparam int ADDR_W = 2;
  localparam int TIMEOUT_DEF = 30;
  typedef enum logic [3:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    WAIT_TILL_EMPTY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR
`ifdef ROUTER_CTRL_DROP_EN
    , DROP_PKT
`endif
  } state_t;
endpackage

// File: rtl/router_ctrl_if.sv
// router_ctrl_if: controller-side bus; master is the controller, slave is the surrounding datapath
interface router_ctrl_if;
  import router_pkg::*;
  logic pkt_valid;
  logic [ADDR_W-1:0] din_addr;
  logic [PORTS-1:0] fifo_full_vec, fifo_empty_vec, read_enb;
  logic parity_done, low_pkt_valid;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic write_enb_reg, busy, fifo_full;
  logic [PORTS-1:0] write_enb, valid_out, soft_reset;
  modport master (
    input pkt_valid, din_addr, fifo_full_vec, fifo_empty_vec, read_enb, parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output write_enb_reg, busy, fifo_full, write_enb, valid_out, soft_reset
  );
  modport slave (
    output pkt_valid, din_addr, fifo_full_vec, fifo_empty_vec, read_enb, parity_done, low_pkt_valid,
    input detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input write_enb_reg, busy, fifo_full, write_enb, valid_out, soft_reset
  );
endinterface

// File: rtl/router_port_timer.sv
// router_port_timer: counts unread cycles on one output port and emits a one-cycle soft_reset at TIMEOUT
module router_port_timer import router_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic read,
  output logic soft_reset
);
  logic [4:0] cnt;
  logic inc, hit;
  assign inc = valid && !read;
  assign hit = inc && cnt == 5'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (!rst) begin
      cnt <= '0;
      soft_reset <= 1'b0;
    end else begin
      cnt <= inc && !hit ? cnt + 5'd1 : '0;
      soft_reset <= hit;
    end
endmodule

// File: rtl/router_ctrl.sv
// router_ctrl: packet router FSM with per-port read timeouts; ROUTER_CTRL_DROP_EN adds DROP_PKT for address-3 packets
module router_ctrl import router_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic rst,
  router_ctrl_if.master bus
);
  state_t st, nxt;
  logic [ADDR_W-1:0] addr;
  logic [3:0] full4, empty4, sr4;
  logic [PORTS-1:0] sr;
  // address 3 indexes the padding bit so it reads as not-full / not-empty / no soft reset
  assign full4 = {1'b0, bus.fifo_full_vec};
  assign empty4 = {1'b0, bus.fifo_empty_vec};
  assign sr4 = {1'b0, sr};
  always_ff @(posedge clk)
    if (!rst) begin
      st <= DECODE_ADDRESS;
      addr <= '0;
    end else begin
      st <= nxt;
      if (st == DECODE_ADDRESS && bus.pkt_valid) addr <= bus.din_addr;
    end
  always_comb begin
    nxt = st;
    case (st)
      DECODE_ADDRESS: begin
        if (bus.pkt_valid && bus.din_addr != 2'd3)
          nxt = empty4[bus.din_addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`ifdef ROUTER_CTRL_DROP_EN
        else if (bus.pkt_valid) nxt = DROP_PKT;
`endif
      end
      LOAD_FIRST_DATA:    nxt = LOAD_DATA;
      LOAD_DATA:          nxt = bus.fifo_full ? FIFO_FULL_STATE : !bus.pkt_valid ? LOAD_PARITY : LOAD_DATA;
      FIFO_FULL_STATE:    nxt = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    nxt = bus.parity_done ? DECODE_ADDRESS : bus.low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
      LOAD_PARITY:        nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:    nxt = empty4[addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`ifdef ROUTER_CTRL_DROP_EN
      DROP_PKT:           nxt = bus.pkt_valid ? DROP_PKT : DECODE_ADDRESS;
`endif
      default:            nxt = DECODE_ADDRESS;
    endcase
    if (st != DECODE_ADDRESS && sr4[addr]) nxt = DECODE_ADDRESS;
  end
  assign bus.detect_add = st == DECODE_ADDRESS;
  assign bus.lfd_state = st == LOAD_FIRST_DATA;
  assign bus.ld_state = st == LOAD_DATA;
  assign bus.laf_state = st == LOAD_AFTER_FULL;
  assign bus.full_state = st == FIFO_FULL_STATE;
  assign bus.rst_int_reg = st == CHECK_PARITY_ERROR;
  assign bus.write_enb_reg = st inside {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL};
`ifdef ROUTER_CTRL_DROP_EN
  assign bus.busy = !(st inside {DECODE_ADDRESS, LOAD_DATA, DROP_PKT});
`else
  assign bus.busy = !(st inside {DECODE_ADDRESS, LOAD_DATA});
`endif
  assign bus.write_enb = bus.write_enb_reg ? 3'b001 << addr : 3'b000;
  assign bus.fifo_full = full4[addr];
  assign bus.valid_out = ~bus.fifo_empty_vec;
  assign bus.soft_reset = sr;
  for (genvar k = 0; k < PORTS; k++) begin : g_timer
    router_port_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk(clk),
      .rst(rst),
      .valid(bus.valid_out[k]),
      .read(bus.read_enb[k]),
      .soft_reset(sr[k])
    );
  end
endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: directed stimulus with a per-cycle expectation queue checked by an independent monitor
module tb_router_ctrl;
  import router_pkg::*;
  typedef struct {
    string tag;
    logic [17:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  router_ctrl_if bus();
  router_ctrl #(.TIMEOUT(30)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  string tag = "reset";
  task automatic cyc(input state_t s, input logic [2:0] we = 3'b000, input logic [2:0] sr = 3'b000, input logic ff = 1'b0);
    exp_t e;
    logic b;
    b = !(s inside {DECODE_ADDRESS, LOAD_DATA});
`ifdef ROUTER_CTRL_DROP_EN
    if (s == DROP_PKT) b = 1'b0;
`endif
    e.tag = tag;
    e.v = {s == DECODE_ADDRESS, s == LOAD_FIRST_DATA, s == LOAD_DATA, s == LOAD_AFTER_FULL,
           s == FIFO_FULL_STATE, s == CHECK_PARITY_ERROR,
           s inside {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL}, b, we, sr, ff, ~bus.fifo_empty_vec};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n, input state_t s, input logic [2:0] we = 3'b000, input logic [2:0] sr = 3'b000, input logic ff = 1'b0);
    for (int i = 0; i < n; i++) cyc(s, we, sr, ff);
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    logic [17:0] a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state, bus.rst_int_reg,
           bus.write_enb_reg, bus.busy, bus.write_enb, bus.soft_reset, bus.fifo_full, bus.valid_out};
      checks++;
      if (a !== e.v) begin
        failures++;
        $display("FAIL %s @%0t: got %b expected %b (dec,wer,busy,we,sr,ff,vo)", e.tag, $time, a, e.v);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.pkt_valid = 1'b0;
    bus.din_addr = 2'd0;
    bus.fifo_full_vec = 3'b000;
    bus.fifo_empty_vec = 3'b111;
    bus.read_enb = 3'b000;
    bus.parity_done = 1'b0;
    bus.low_pkt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(DECODE_ADDRESS);
    rst = 1'b1;
    cyc(DECODE_ADDRESS);
    tag = "pkt_port1";
    bus.pkt_valid = 1'b1;
    bus.din_addr = 2'd1;
    cyc(DECODE_ADDRESS);
    cyc(LOAD_FIRST_DATA);
    run(3, LOAD_DATA, 3'b010);
    bus.pkt_valid = 1'b0;
    cyc(LOAD_DATA, 3'b010);
    cyc(LOAD_PARITY, 3'b010);
    cyc(CHECK_PARITY_ERROR);
    cyc(DECODE_ADDRESS);
    tag = "wait_empty";
    bus.fifo_empty_vec = 3'b011;
    bus.pkt_valid = 1'b1;
    bus.din_addr = 2'd2;
    cyc(DECODE_ADDRESS);
    run(5, WAIT_TILL_EMPTY);
    bus.fifo_empty_vec = 3'b111;
    cyc(WAIT_TILL_EMPTY);
    cyc(LOAD_FIRST_DATA);
    bus.pkt_valid = 1'b0;
    cyc(LOAD_DATA, 3'b100);
    cyc(LOAD_PARITY, 3'b100);
    cyc(CHECK_PARITY_ERROR);
    cyc(DECODE_ADDRESS);
    tag = "fifo_full";
    bus.pkt_valid = 1'b1;
    bus.din_addr = 2'd0;
    cyc(DECODE_ADDRESS);
    cyc(LOAD_FIRST_DATA);
    run(2, LOAD_DATA, 3'b001);
    bus.fifo_full_vec = 3'b001;
    cyc(LOAD_DATA, 3'b001, 3'b000, 1'b1);
    run(3, FIFO_FULL_STATE, 3'b000, 3'b000, 1'b1);
    bus.fifo_full_vec = 3'b000;
    cyc(FIFO_FULL_STATE);
    cyc(LOAD_AFTER_FULL, 3'b001);
    bus.pkt_valid = 1'b0;
    cyc(LOAD_DATA, 3'b001);
    cyc(LOAD_PARITY, 3'b001);
    cyc(CHECK_PARITY_ERROR);
    cyc(DECODE_ADDRESS);
    tag = "laf_branches";
    bus.pkt_valid = 1'b1;
    cyc(DECODE_ADDRESS);
    cyc(LOAD_FIRST_DATA);
    bus.fifo_full_vec = 3'b001;
    cyc(LOAD_DATA, 3'b001, 3'b000, 1'b1);
    bus.fifo_full_vec = 3'b000;
    cyc(FIFO_FULL_STATE);
    bus.low_pkt_valid = 1'b1;
    cyc(LOAD_AFTER_FULL, 3'b001);
    bus.low_pkt_valid = 1'b0;
    cyc(LOAD_PARITY, 3'b001);
    bus.fifo_full_vec = 3'b001;
    cyc(CHECK_PARITY_ERROR, 3'b000, 3'b000, 1'b1);
    bus.fifo_full_vec = 3'b000;
    cyc(FIFO_FULL_STATE);
    bus.parity_done = 1'b1;
    cyc(LOAD_AFTER_FULL, 3'b001);
    bus.parity_done = 1'b0;
    bus.pkt_valid = 1'b0;
    cyc(DECODE_ADDRESS);
    tag = "timeout_pulse";
    bus.fifo_empty_vec = 3'b110;
    run(30, DECODE_ADDRESS);
    cyc(DECODE_ADDRESS, 3'b000, 3'b001);
    cyc(DECODE_ADDRESS);
    bus.fifo_empty_vec = 3'b111;
    cyc(DECODE_ADDRESS);
    tag = "timeout_read29";
    bus.fifo_empty_vec = 3'b110;
    run(28, DECODE_ADDRESS);
    bus.read_enb = 3'b001;
    cyc(DECODE_ADDRESS);
    bus.read_enb = 3'b000;
    run(3, DECODE_ADDRESS);
    bus.fifo_empty_vec = 3'b111;
    cyc(DECODE_ADDRESS);
    tag = "soft_reset_abort";
    bus.pkt_valid = 1'b1;
    bus.din_addr = 2'd1;
    cyc(DECODE_ADDRESS);
    bus.fifo_empty_vec = 3'b101;
    cyc(LOAD_FIRST_DATA);
    run(29, LOAD_DATA, 3'b010);
    cyc(LOAD_DATA, 3'b010, 3'b010);
    bus.pkt_valid = 1'b0;
    cyc(DECODE_ADDRESS);
    bus.fifo_empty_vec = 3'b111;
    cyc(DECODE_ADDRESS);
    tag = "reset_mid_packet";
    bus.pkt_valid = 1'b1;
    bus.din_addr = 2'd2;
    cyc(DECODE_ADDRESS);
    cyc(LOAD_FIRST_DATA);
    cyc(LOAD_DATA, 3'b100);
    rst = 1'b0;
    cyc(LOAD_DATA, 3'b100);
    rst = 1'b1;
    bus.pkt_valid = 1'b0;
    cyc(DECODE_ADDRESS);
    tag = "addr3_header";
    bus.pkt_valid = 1'b1;
    bus.din_addr = 2'd3;
    cyc(DECODE_ADDRESS);
    bus.fifo_full_vec = 3'b111;
`ifdef ROUTER_CTRL_DROP_EN
    run(2, DROP_PKT);
    bus.pkt_valid = 1'b0;
    cyc(DROP_PKT);
`else
    run(2, DECODE_ADDRESS);
    bus.pkt_valid = 1'b0;
    cyc(DECODE_ADDRESS);
`endif
    bus.fifo_full_vec = 3'b000;
    cyc(DECODE_ADDRESS);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations never checked", q.size());
    end
    if (checks < 12) begin
      failures++;
      $display("FAIL count: only %0d checks ran", checks);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
